// File: rtl/microtapeout_switch_loader_pkg.sv
// Shared types and defaults for the microtapeout switch loader.
// A key is {mode, switches}, with the mode bit in the MSB.
package microtapeout_switch_loader_pkg;

    localparam int DEFAULT_WIDTH           = 6;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_e;

    typedef logic [DEFAULT_WIDTH:0] key_t;

endpackage

// File: rtl/microtapeout_debounce.sv
// Two-flop synchroniser followed by a saturating stability counter.
// Emits the current candidate plus a one-cycle pulse when it first settles.
module microtapeout_debounce
    import microtapeout_switch_loader_pkg::*;
#(
    parameter int W               = DEFAULT_WIDTH + 1,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sample_raw,
    output logic [W-1:0] cand,
    output logic         settled,
    output logic         stable
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [W-1:0]     sync1_q, sync1_d;
    logic [W-1:0]     sync2_q, sync2_d;
    logic [W-1:0]     cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Settled fires only on the transition into saturation, so it is a single pulse.
    always_comb begin
        sync1_d = sample_raw;
        sync2_d = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        settled = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d   = cnt_q + 1'b1;
            settled = (cnt_q == CNT_MAX - 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cand   = cand_q;
    assign stable = (cnt_q == CNT_MAX);

endmodule

// File: rtl/microtapeout_switch_loader.sv
// Debounced switch loader: commits each newly settled {mode, switches} key
// exactly once, as a one-cycle write into either the page or input register.
module microtapeout_switch_loader
    import microtapeout_switch_loader_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             mode_raw,
    output logic [WIDTH-1:0] page_out,
    output logic [WIDTH-1:0] in_out,
    output logic             page_we,
    output logic             in_we,
    output logic             busy
);

    logic [WIDTH:0] cand;
    logic           settled;
    logic           stable;

    state_e         state_q, state_d;
    logic [WIDTH:0] pending_q, pending_d;
    logic [WIDTH:0] last_key_q, last_key_d;
    logic [WIDTH-1:0] page_q, page_d;
    logic [WIDTH-1:0] in_q, in_d;
    logic           page_we_q, page_we_d;
    logic           in_we_q, in_we_d;

    microtapeout_debounce #(
        .W              (WIDTH + 1),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .sample_raw({mode_raw, sw_raw}),
        .cand      (cand),
        .settled   (settled),
        .stable    (stable)
    );

    // A settled key equal to the last commit is a glitch that returned home; ignore it.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        last_key_d = last_key_q;
        page_d     = page_q;
        in_d       = in_q;
        page_we_d  = 1'b0;
        in_we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (settled && (cand != last_key_q)) begin
                    state_d   = COMMIT;
                    pending_d = cand;
                end
            end
            COMMIT: begin
                state_d    = IDLE;
                last_key_d = pending_q;
                if (pending_q[WIDTH]) begin
                    page_d    = pending_q[WIDTH-1:0];
                    page_we_d = 1'b1;
                end else begin
                    in_d    = pending_q[WIDTH-1:0];
                    in_we_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            last_key_q <= '0;
            page_q     <= '0;
            in_q       <= '0;
            page_we_q  <= 1'b0;
            in_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            last_key_q <= last_key_d;
            page_q     <= page_d;
            in_q       <= in_d;
            page_we_q  <= page_we_d;
            in_we_q    <= in_we_d;
        end
    end

    assign page_out = page_q;
    assign in_out   = in_q;
    assign page_we  = page_we_q;
    assign in_we    = in_we_q;
    assign busy     = !stable || (state_q == COMMIT);

endmodule

// File: tb/tb_microtapeout_switch_loader.sv
// Directed bench for the switch loader: every strobe is expected exactly
// eight rising edges after the raw inputs change (sync, load, four counts, commit).
module tb_microtapeout_switch_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] sw_raw = 6'h00;
    logic       mode_raw = 1'b0;
    logic [5:0] page_out;
    logic [5:0] in_out;
    logic       page_we;
    logic       in_we;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    microtapeout_switch_loader dut (
        .clk     (clk),
        .rst     (rst),
        .sw_raw  (sw_raw),
        .mode_raw(mode_raw),
        .page_out(page_out),
        .in_out  (in_out),
        .page_we (page_we),
        .in_we   (in_we),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [5:0] s);
        mode_raw = m;
        sw_raw   = s;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expectQuiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            stepCycle();
            checkOutput({tag, "_nostrobe"}, {6'b0, page_we, in_we}, 8'h00);
        end
    endtask

    task automatic expectCommit(input string tag, input logic is_page,
                                input logic [5:0] exp_page, input logic [5:0] exp_in);
        stepCycle();
        checkOutput({tag, "_we"}, {6'b0, page_we, in_we}, {6'b0, is_page, !is_page});
        checkOutput({tag, "_page"}, {2'b0, page_out}, {2'b0, exp_page});
        checkOutput({tag, "_in"}, {2'b0, in_out}, {2'b0, exp_in});
        stepCycle();
        checkOutput({tag, "_we_drop"}, {6'b0, page_we, in_we}, 8'h00);
    endtask

    initial begin
        $display("[TB] start");

        // Reset hold with a page setting already on the switches
        applyStimulus(1'b1, 6'h2A);
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("rst_page", {2'b0, page_out}, 8'h00);
        checkOutput("rst_in", {2'b0, in_out}, 8'h00);
        checkOutput("rst_we", {6'b0, page_we, in_we}, 8'h00);
        checkOutput("rst_busy", {7'b0, busy}, 8'h01);
        rst = 1'b0;
        expectQuiet("post_rst", 7);
        expectCommit("post_rst", 1'b1, 6'h2A, 6'h00);
        checkOutput("idle_busy", {7'b0, busy}, 8'h00);

        // Input commits: zero first (new key because of the mode flip), then 0x15
        applyStimulus(1'b0, 6'h00);
        expectQuiet("in_zero", 7);
        expectCommit("in_zero", 1'b0, 6'h2A, 6'h00);
        applyStimulus(1'b0, 6'h15);
        expectQuiet("in15", 7);
        expectCommit("in15", 1'b0, 6'h2A, 6'h15);

        // Bounce between 0x16 and 0x15 every two cycles, then hold 0x16
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, (i % 2 == 0) ? 6'h16 : 6'h15);
            expectQuiet("bounce", 2);
        end
        applyStimulus(1'b0, 6'h16);
        expectQuiet("in16", 7);
        expectCommit("in16", 1'b0, 6'h2A, 6'h16);

        // Mode-only change copies the switches into the page register
        applyStimulus(1'b0, 6'h3F);
        expectQuiet("in3f", 7);
        expectCommit("in3f", 1'b0, 6'h2A, 6'h3F);
        applyStimulus(1'b1, 6'h3F);
        expectQuiet("mode_flip", 7);
        expectCommit("mode_flip", 1'b1, 6'h3F, 6'h3F);
        expectQuiet("hold100", 100);
        checkOutput("hold_busy", {7'b0, busy}, 8'h00);

        // Short excursion that returns to the committed key before settling
        applyStimulus(1'b0, 6'h05);
        expectQuiet("in05", 7);
        expectCommit("in05", 1'b0, 6'h3F, 6'h05);
        applyStimulus(1'b0, 6'h06);
        expectQuiet("glitch", 3);
        applyStimulus(1'b0, 6'h05);
        expectQuiet("glitch_back", 15);
        checkOutput("glitch_in", {2'b0, in_out}, 8'h05);
        checkOutput("glitch_busy", {7'b0, busy}, 8'h00);

        // Reset lands on the edge that would have produced the strobe
        applyStimulus(1'b0, 6'h09);
        expectQuiet("pre_rst", 7);
        rst = 1'b1;
        stepCycle();
        checkOutput("midrst_we", {6'b0, page_we, in_we}, 8'h00);
        checkOutput("midrst_page", {2'b0, page_out}, 8'h00);
        checkOutput("midrst_in", {2'b0, in_out}, 8'h00);
        checkOutput("midrst_busy", {7'b0, busy}, 8'h01);
        rst = 1'b0;
        expectQuiet("recommit", 7);
        expectCommit("recommit", 1'b0, 6'h00, 6'h09);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/microtapeout_switch_loader.md
Name: microtapeout_switch_loader

Overview:
- Input stage directly upstream of the page/input register pair that drives the cell multiplexer in the microtapeout design.
- Synchronises and debounces the raw switch bank and the page-mode switch.
- Commits each settled setting exactly once, as a write strobe to either the page register or the input register.
- Replaces "write on every clock edge" with one clean, observable write per deliberate switch change.

Parameters:
- WIDTH, 6: switch bank width; also the width of page and input words.
- DEBOUNCE_CYCLES, 4: consecutive identical synchronised samples required before a value counts as settled; legal range 1..255.
- CNT_W, 8: stability counter width; must hold DEBOUNCE_CYCLES.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sw_raw  in  WIDTH  raw switch levels; asynchronous to clk, may bounce.
- mode_raw  in  1  raw page-mode switch; 1 = page write, 0 = input write.
- page_out  out  WIDTH  committed page word (registered).
- in_out  out  WIDTH  committed input word (registered).
- page_we  out  1  one-cycle pulse, high in the cycle page_out takes a new value.
- in_we  out  1  one-cycle pulse, high in the cycle in_out takes a new value.
- busy  out  1  high while the sample is unsettled or a commit is in flight.

Behaviour:
- Reset (rst high at an edge): all state clears.
  - Cleared: sync flops, candidate, counter, last committed key {mode, sw}. All outputs go to 0.
  - FSM returns to IDLE.
  - A reset mid-debounce or mid-commit discards the pending value; no strobe appears in the cycle after reset.
- Synchroniser: two flops on {mode_raw, sw_raw} as one (WIDTH+1)-bit sample.
- Debounce: compare the synchronised sample S against the candidate C.
  - S != C: C <= S and cnt <= 0.
  - S == C and cnt < DEBOUNCE_CYCLES: cnt increments.
  - cnt saturates at DEBOUNCE_CYCLES.
- Settled event: asserted on the edge where cnt goes from DEBOUNCE_CYCLES-1 to DEBOUNCE_CYCLES.
  - Fires once per settled value. A saturated counter never re-fires.
  - Any sample change before saturation restarts the count (bounce rejection).
- Commit decision on a settled event: if C differs from the last committed key, go IDLE -> COMMIT and latch C as the pending key. Otherwise stay in IDLE.
- COMMIT state (exactly one cycle, then back to IDLE):
  - Pending mode = 1: page_out <= pending sw and page_we = 1.
  - Pending mode = 0: in_out <= pending sw and in_we = 1.
  - Last committed key <= pending key.
- Flipping the mode switch alone, with switches unchanged, is a new key: it copies the switches into the other register.
- A change that returns to the last committed key before settling produces no strobe.
- Latency: raw stable from rising edge k onward.
  - Sync stage 2 holds the value after edge k+1; C loads at k+2.
  - Settled event occurs at edge k+2+DEBOUNCE_CYCLES.
  - Output register updates and the strobe is high after edge k+3+DEBOUNCE_CYCLES (7 cycles for the default).
- Strobe rules: page_we and in_we are never high together and are never high in consecutive cycles.
  - A sample change during COMMIT is not lost: C and cnt keep tracking while the commit completes.
- busy = (cnt != DEBOUNCE_CYCLES) | (state == COMMIT). busy is 0 after reset only once a full debounce of the reset value completes.

Decomposition:
- Shared package: state enum {IDLE, COMMIT}, default WIDTH and DEBOUNCE_CYCLES constants, and the key type (WIDTH+1 bits, mode in the MSB).
- One natural sub-module: microtapeout_debounce. It holds the synchroniser, candidate, and counter, and emits C plus a one-cycle settled pulse.
- The FSM, committed-key compare, and output registers live in the top.

Test Plan:
- Reset hold: rst=1 for 3 cycles with sw_raw=6'h2A, mode_raw=1 -> page_out=in_out=0 and no strobes. After release, page_we pulses once, 7 cycles after the first post-reset sampling edge, with page_out=6'h2A.
- Input commit: mode_raw=0, sw_raw 6'h00->6'h15 stable -> in_we high for exactly one cycle 7 cycles later, in_out=6'h15, page_out unchanged.
- Bounce rejection: sw_raw toggles 6'h15/6'h16 every 2 cycles for 20 cycles, then holds 6'h16 -> no strobe during toggling; a single in_we with in_out=6'h16 7 cycles after the final change.
- Mode-only change: sw_raw=6'h3F held, mode_raw 0->1 -> one page_we with page_out=6'h3F; holding 100 more cycles produces no further strobes.
- Return-to-committed glitch: committed in=6'h05; sw_raw pulses to 6'h06 for 3 cycles and returns to 6'h05 -> no strobe, in_out stays 6'h05.
- Reset mid-operation: rst asserted on the cycle before an expected in_we -> no strobe, all outputs 0; the held value re-commits 7 cycles after rst deasserts.
